// File: rtl/dm_load_unit.sv
// dm_load_unit: MIPS data-memory load unit with valid/ready handshakes on request, bus and response.
// Optional macro DM_MISALIGN_SPLIT_EN: misaligned loads are legal, split into two beats when they cross a beat.
module dm_load_unit #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [2:0]    req_mode,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err
);
  localparam int B  = DW / 8;
  localparam int OW = $clog2(B);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  function automatic logic [3:0] size_of(input logic [2:0] mode);
    case (mode)
      3'd0:       return 4'd4;
      3'd1, 3'd2: return 4'd2;
      3'd3, 3'd4: return 4'd1;
      default:    return 4'd8;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [OW-1:0] off_q, off_d;
  logic [2:0]    mode_q, mode_d;
  logic [DW-1:0] beat0_q, beat0_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          req_ready_q, req_ready_d;
  logic          mem_req_valid_q, mem_req_valid_d;
  logic          rsp_valid_q, rsp_valid_d;

  // Request decode: decides up front whether the load is rejected without any bus traffic.
  logic req_bad_mode, req_err;
  assign req_bad_mode = (req_mode > 3'd5) || ((req_mode == 3'd5) && (DW != 64));
`ifdef DM_MISALIGN_SPLIT_EN
  assign req_err = req_bad_mode;
`else
  logic [3:0] req_size;
  logic       req_misal;
  assign req_size  = size_of(req_mode);
  assign req_misal = ((4'(req_addr[OW-1:0]) & (req_size - 4'd1)) != 4'd0);
  assign req_err   = req_bad_mode || req_misal;
`endif

  logic [3:0]    cur_size;
  logic [6:0]    size_bits;
  logic [DW-1:0] beat0_v, beat1_v, low, ext;
  logic          sign_fill;

  // The beat arriving this cycle is used directly, so the result registers on the final rvalid.
  always_comb begin
    cur_size  = size_of(mode_q);
    size_bits = {cur_size, 3'b000};
    beat0_v   = (state_q == WAIT0) ? mem_rdata : beat0_q;
`ifdef DM_MISALIGN_SPLIT_EN
    beat1_v   = (state_q == WAIT1) ? mem_rdata : '0;
`else
    beat1_v   = '0;
`endif
    low       = DW'({beat1_v, beat0_v} >> {off_q, 3'b000});
    sign_fill = (mode_q == 3'd1) ? low[15] : ((mode_q == 3'd3) ? low[7] : 1'b0);
    for (int i = 0; i < DW; i++) begin
      ext[i] = (7'(i) < size_bits) ? low[i] : sign_fill;
    end
  end

`ifdef DM_MISALIGN_SPLIT_EN
  logic crossing;
  assign crossing = (5'(off_q) + 5'(cur_size)) > 5'(B);
`endif

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    mode_d     = mode_q;
    beat0_d    = beat0_q;
    mem_addr_d = mem_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_ready_q && req_valid) begin
          off_d  = req_addr[OW-1:0];
          mode_d = req_mode;
          if (req_err) begin
            state_d    = RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d    = REQ0;
            mem_addr_d = {req_addr[AW-1:OW], {OW{1'b0}}};
          end
        end
      end
      REQ0: if (mem_req_ready) state_d = WAIT0;
      WAIT0: begin
        if (mem_rvalid) begin
          beat0_d = mem_rdata;
`ifdef DM_MISALIGN_SPLIT_EN
          if (crossing) begin
            state_d    = REQ1;
            mem_addr_d = mem_addr_q + AW'(B);
          end else
`endif
          begin
            state_d    = RESP;
            rsp_data_d = ext;
            rsp_err_d  = 1'b0;
          end
        end
      end
`ifdef DM_MISALIGN_SPLIT_EN
      REQ1: if (mem_req_ready) state_d = WAIT1;
      WAIT1: begin
        if (mem_rvalid) begin
          state_d    = RESP;
          rsp_data_d = ext;
          rsp_err_d  = 1'b0;
        end
      end
`endif
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d     = (state_d == IDLE);
    mem_req_valid_d = (state_d == REQ0) || (state_d == REQ1);
    rsp_valid_d     = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      off_q           <= '0;
      mode_q          <= '0;
      beat0_q         <= '0;
      mem_addr_q      <= '0;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
      req_ready_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
      rsp_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      off_q           <= off_d;
      mode_q          <= mode_d;
      beat0_q         <= beat0_d;
      mem_addr_q      <= mem_addr_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      rsp_valid_q     <= rsp_valid_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// tb_dm_load_unit: scoreboard bench for dm_load_unit, a DW=32 instance with a memory responder and a DW=64 instance.
module tb_dm_load_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        req_valid32, req_ready32, mem_req_valid32, mem_req_ready32, mem_rvalid32;
  logic        rsp_valid32, rsp_ready32, rsp_err32;
  logic [31:0] req_addr32, mem_addr32, mem_rdata32, rsp_data32;
  logic [2:0]  req_mode32;

  logic        req_valid64, req_ready64, mem_req_valid64, mem_req_ready64, mem_rvalid64;
  logic        rsp_valid64, rsp_ready64, rsp_err64;
  logic [31:0] req_addr64, mem_addr64;
  logic [63:0] mem_rdata64, rsp_data64;
  logic [2:0]  req_mode64;

  dm_load_unit #(.DW(32), .AW(32)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid32), .req_ready(req_ready32), .req_addr(req_addr32), .req_mode(req_mode32),
    .mem_req_valid(mem_req_valid32), .mem_req_ready(mem_req_ready32), .mem_addr(mem_addr32),
    .mem_rvalid(mem_rvalid32), .mem_rdata(mem_rdata32),
    .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready32), .rsp_data(rsp_data32), .rsp_err(rsp_err32)
  );

  dm_load_unit #(.DW(64), .AW(32)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_addr(req_addr64), .req_mode(req_mode64),
    .mem_req_valid(mem_req_valid64), .mem_req_ready(mem_req_ready64), .mem_addr(mem_addr64),
    .mem_rvalid(mem_rvalid64), .mem_rdata(mem_rdata64),
    .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready64), .rsp_data(rsp_data64), .rsp_err(rsp_err64)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  logic [31:0] mem32 [logic [31:0]];
  logic [31:0] seen32[$];
  int          stall32 = 0;
  int          mreq_cnt32 = 0;
  bit          stray32 = 1'b0;
  bit          hs_pending = 1'b0;
  logic [31:0] hs_addr;

  localparam int NB = 8;
  localparam logic [31:0] BB_ADDR [NB] = '{32'h102, 32'h103, 32'h500, 32'h501, 32'h502, 32'h502, 32'h502, 32'h504};
  localparam logic [2:0]  BB_MODE [NB] = '{3'd1, 3'd4, 3'd3, 3'd3, 3'd3, 3'd1, 3'd2, 3'd0};
  localparam logic [31:0] BB_EXP  [NB] = '{32'hFFFF8765, 32'h00000087, 32'h00000001, 32'h0000007F,
                                           32'hFFFFFFFF, 32'hFFFF80FF, 32'h000080FF, 32'hDEADBEEF};

  localparam logic [31:0] MA_ADDR [2] = '{32'h102, 32'h101};
  localparam logic [2:0]  MA_MODE [2] = '{3'd0, 3'd2};
`ifdef DM_MISALIGN_SPLIT_EN
  localparam logic [31:0] MA_EXP   [2] = '{32'hAA998765, 32'h00006543};
  localparam bit          MA_ERR   [2] = '{1'b0, 1'b0};
  localparam int          MA_BEATS [2] = '{2, 1};
`else
  localparam logic [31:0] MA_EXP   [2] = '{32'h0, 32'h0};
  localparam bit          MA_ERR   [2] = '{1'b1, 1'b1};
  localparam int          MA_BEATS [2] = '{0, 0};
`endif

  localparam logic [31:0] ER_ADDR [3] = '{32'h000, 32'h010, 32'h022};
  localparam logic [2:0]  ER_MODE [3] = '{3'd5, 3'd7, 3'd6};

  localparam logic [31:0] W_ADDR [4] = '{32'h08, 32'h0C, 32'h13, 32'h16};
  localparam logic [2:0]  W_MODE [4] = '{3'd5, 3'd0, 3'd7, 3'd1};
  localparam logic [63:0] W_BEAT [4] = '{64'h0123456789ABCDEF, 64'h89ABCDEF01234567, 64'h0, 64'h8001000000000000};
  localparam logic [63:0] W_EXP  [4] = '{64'h0123456789ABCDEF, 64'h0000000089ABCDEF, 64'h0, 64'hFFFFFFFFFFFF8001};
  localparam bit          W_ERR  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [31:0] W_MADR [4] = '{32'h08, 32'h08, 32'h0, 32'h10};

  // Memory model for the 32-bit unit: accepts reads (with optional stall), returns data one cycle later.
  initial begin
    mem_req_ready32 = 1'b0;
    mem_rvalid32    = 1'b0;
    mem_rdata32     = 32'h0;
    forever begin
      @(negedge clk);
      mem_rvalid32 = 1'b0;
      mem_rdata32  = 32'hA5A5A5A5;
      if (hs_pending) begin
        mem_rvalid32 = 1'b1;
        mem_rdata32  = mem32.exists(hs_addr) ? mem32[hs_addr] : 32'h0;
        seen32.push_back(hs_addr);
        hs_pending   = 1'b0;
      end else if (stray32) begin
        mem_rvalid32 = 1'b1;
        mem_rdata32  = 32'h12345678;
        stray32      = 1'b0;
      end
      if (mem_req_valid32) begin
        mreq_cnt32++;
        if (stall32 > 0) begin
          mem_req_ready32 = 1'b0;
          stall32--;
        end else begin
          mem_req_ready32 = 1'b1;
        end
      end else begin
        mem_req_ready32 = 1'b0;
      end
      if (mem_req_ready32 && mem_req_valid32) begin
        hs_pending = 1'b1;
        hs_addr    = mem_addr32;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic issue32(input logic [31:0] a, input logic [2:0] m, output bit ok);
    int n;
    n = 0;
    req_valid32 = 1'b1;
    req_addr32  = a;
    req_mode32  = m;
    while (!req_ready32 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready32;
    @(negedge clk);
    req_valid32 = 1'b0;
  endtask

  task automatic get_rsp32(output logic [31:0] d, output logic e, output bit ok, output int lat);
    int n;
    n = 0;
    while (!rsp_valid32 && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok  = rsp_valid32;
    d   = rsp_data32;
    e   = rsp_err32;
    lat = n + 1;
    @(negedge clk);
  endtask

  task automatic load64(input logic [31:0] a, input logic [2:0] m, input logic [63:0] beat,
                        output bit got_req, output logic [31:0] got_addr,
                        output logic [63:0] d, output logic e, output bit ok, output int lat);
    int n;
    req_valid64 = 1'b1;
    req_addr64  = a;
    req_mode64  = m;
    @(negedge clk);
    req_valid64 = 1'b0;
    n = 1;
    got_req  = mem_req_valid64;
    got_addr = mem_addr64;
    if (got_req) begin
      mem_req_ready64 = 1'b1;
      @(negedge clk);
      mem_req_ready64 = 1'b0;
      mem_rvalid64    = 1'b1;
      mem_rdata64     = beat;
      n++;
      @(negedge clk);
      mem_rvalid64    = 1'b0;
      mem_rdata64     = 64'h0;
      n++;
    end
    while (!rsp_valid64 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok  = rsp_valid64;
    d   = rsp_data64;
    e   = rsp_err64;
    lat = n;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid32 = 1'b0; req_addr32 = '0; req_mode32 = '0; rsp_ready32 = 1'b1;
    req_valid64 = 1'b0; req_addr64 = '0; req_mode64 = '0; rsp_ready64 = 1'b1;
    mem_req_ready64 = 1'b0; mem_rvalid64 = 1'b0; mem_rdata64 = '0;
    repeat (3) @(negedge clk);
    total++; if ({req_ready32, mem_req_valid32, rsp_valid32, rsp_err32} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags32: got %b want 0000", {req_ready32, mem_req_valid32, rsp_valid32, rsp_err32}); end
    total++; if (mem_addr32 !== 32'h0) begin bad++; $display("FAIL reset_mem_addr32: got %h want 0", mem_addr32); end
    total++; if (rsp_data32 !== 32'h0) begin bad++; $display("FAIL reset_rsp_data32: got %h want 0", rsp_data32); end
    total++; if ({req_ready64, mem_req_valid64, rsp_valid64, rsp_err64} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags64: got %b want 0000", {req_ready64, mem_req_valid64, rsp_valid64, rsp_err64}); end
    reset = 1'b1;
    @(negedge clk);
    total++; if ({req_ready32, req_ready64} !== 2'b11) begin
      bad++; $display("FAIL reset_req_ready_rise: got %b want 11", {req_ready32, req_ready64}); end
    $display("reset released: req_ready32=%b req_ready64=%b", req_ready32, req_ready64);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        e;
    bit          ok_i, ok_r;
    int          lat, c0;
    exp_t        ex;
    for (int i = 0; i < NB; i++) begin
      seen32.delete();
      c0 = mreq_cnt32;
      exp_q.push_back('{data: {32'h0, BB_EXP[i]}, err: 1'b0});
      issue32(BB_ADDR[i], BB_MODE[i], ok_i);
      get_rsp32(d, e, ok_r, lat);
      ex = exp_q.pop_front();
      $display("load32 addr=%h mode=%0d data=%h err=%b lat=%0d", BB_ADDR[i], BB_MODE[i], d, e, lat);
      total++; if (!(ok_i && ok_r)) begin bad++; $display("FAIL b2b_handshake[%0d]: got req=%b rsp=%b want 1 1", i, ok_i, ok_r); end
      total++; if (d !== ex.data[31:0]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, d, ex.data[31:0]); end
      total++; if (e !== ex.err) begin bad++; $display("FAIL b2b_err[%0d]: got %b want %b", i, e, ex.err); end
      total++; if (lat !== 3) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want 3", i, lat); end
      total++; if ((mreq_cnt32 - c0) !== 1 || seen32.size() !== 1) begin
        bad++; $display("FAIL b2b_beats[%0d]: got valid_cycles=%0d reads=%0d want 1 1", i, mreq_cnt32 - c0, seen32.size()); end
      total++; if (((seen32.size() > 0) ? seen32[0] : 32'hFFFFFFFF) !== (BB_ADDR[i] & ~32'h3)) begin
        bad++; $display("FAIL b2b_mem_addr[%0d]: got %h want %h", i, (seen32.size() > 0) ? seen32[0] : 32'hFFFFFFFF, BB_ADDR[i] & ~32'h3); end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] d;
    logic        e;
    bit          ok_i, ok_r;
    int          lat, c0;
    exp_t        ex;
    for (int i = 0; i < 2; i++) begin
      seen32.delete();
      c0 = mreq_cnt32;
      exp_q.push_back('{data: {32'h0, MA_EXP[i]}, err: MA_ERR[i]});
      issue32(MA_ADDR[i], MA_MODE[i], ok_i);
      get_rsp32(d, e, ok_r, lat);
      ex = exp_q.pop_front();
      $display("load32 misaligned addr=%h mode=%0d data=%h err=%b lat=%0d reads=%0d", MA_ADDR[i], MA_MODE[i], d, e, lat, seen32.size());
      total++; if (!(ok_i && ok_r)) begin bad++; $display("FAIL mis_handshake[%0d]: got req=%b rsp=%b want 1 1", i, ok_i, ok_r); end
      total++; if (d !== ex.data[31:0]) begin bad++; $display("FAIL mis_data[%0d]: got %h want %h", i, d, ex.data[31:0]); end
      total++; if (e !== ex.err) begin bad++; $display("FAIL mis_err[%0d]: got %b want %b", i, e, ex.err); end
      total++; if (lat !== ((MA_BEATS[i] == 0) ? 1 : 1 + 2 * MA_BEATS[i])) begin
        bad++; $display("FAIL mis_latency[%0d]: got %0d want %0d", i, lat, (MA_BEATS[i] == 0) ? 1 : 1 + 2 * MA_BEATS[i]); end
      total++; if ((mreq_cnt32 - c0) !== MA_BEATS[i] || seen32.size() !== MA_BEATS[i]) begin
        bad++; $display("FAIL mis_beats[%0d]: got valid_cycles=%0d reads=%0d want %0d", i, mreq_cnt32 - c0, seen32.size(), MA_BEATS[i]); end
      if (MA_BEATS[i] > 0) begin
        total++; if (((seen32.size() > 0) ? seen32[0] : 32'hFFFFFFFF) !== 32'h100) begin
          bad++; $display("FAIL mis_addr0[%0d]: got %h want 00000100", i, (seen32.size() > 0) ? seen32[0] : 32'hFFFFFFFF); end
      end
      if (MA_BEATS[i] > 1) begin
        total++; if (((seen32.size() > 1) ? seen32[1] : 32'hFFFFFFFF) !== 32'h104) begin
          bad++; $display("FAIL mis_addr1[%0d]: got %h want 00000104", i, (seen32.size() > 1) ? seen32[1] : 32'hFFFFFFFF); end
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic        e;
    bit          ok_i, ok_r;
    int          lat, c0;
    exp_t        ex;
    for (int i = 0; i < 3; i++) begin
      c0 = mreq_cnt32;
      exp_q.push_back('{data: 64'h0, err: 1'b1});
      issue32(ER_ADDR[i], ER_MODE[i], ok_i);
      get_rsp32(d, e, ok_r, lat);
      ex = exp_q.pop_front();
      $display("load32 invalid addr=%h mode=%0d data=%h err=%b lat=%0d", ER_ADDR[i], ER_MODE[i], d, e, lat);
      total++; if (!(ok_i && ok_r)) begin bad++; $display("FAIL err_handshake[%0d]: got req=%b rsp=%b want 1 1", i, ok_i, ok_r); end
      total++; if ({e, d} !== {ex.err, ex.data[31:0]}) begin bad++; $display("FAIL err_result[%0d]: got err=%b data=%h want err=%b data=%h", i, e, d, ex.err, ex.data[31:0]); end
      total++; if (lat !== 1) begin bad++; $display("FAIL err_latency[%0d]: got %0d want 1", i, lat); end
      total++; if ((mreq_cnt32 - c0) !== 0) begin bad++; $display("FAIL err_no_bus[%0d]: got %0d want 0", i, mreq_cnt32 - c0); end
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   n, vcyc;
    exp_t ex;
    mem32[32'h300] = 32'h11223344;
    exp_q.push_back('{data: 64'h11223344, err: 1'b0});
    stall32     = 3;
    rsp_ready32 = 1'b0;
    issue32(32'h300, 3'd0, ok);
    n = 0;
    vcyc = 0;
    while (!rsp_valid32 && n < 40) begin
      if (mem_req_valid32) begin
        vcyc++;
        total++; if (mem_addr32 !== 32'h300) begin bad++; $display("FAIL bp_mem_addr: got %h want 00000300", mem_addr32); end
      end
      @(negedge clk);
      n++;
    end
    total++; if (vcyc !== 4) begin bad++; $display("FAIL bp_valid_cycles: got %0d want 4", vcyc); end
    ex = exp_q.pop_front();
    for (int k = 0; k < 2; k++) begin
      total++; if ({rsp_valid32, req_ready32} !== 2'b10) begin
        bad++; $display("FAIL bp_hold_flags[%0d]: got valid/ready=%b want 10", k, {rsp_valid32, req_ready32}); end
      total++; if (rsp_data32 !== ex.data[31:0]) begin bad++; $display("FAIL bp_hold_data[%0d]: got %h want %h", k, rsp_data32, ex.data[31:0]); end
      @(negedge clk);
    end
    rsp_ready32 = 1'b1;
    total++; if ({rsp_valid32, rsp_err32, rsp_data32} !== {1'b1, 1'b0, ex.data[31:0]}) begin
      bad++; $display("FAIL bp_final: got valid=%b err=%b data=%h want 1 0 %h", rsp_valid32, rsp_err32, rsp_data32, ex.data[31:0]); end
    $display("load32 backpressure addr=00000300 data=%h valid_cycles=%0d", rsp_data32, vcyc);
    @(negedge clk);
    total++; if ({rsp_valid32, req_ready32} !== 2'b01) begin
      bad++; $display("FAIL bp_release: got valid/ready=%b want 01", {rsp_valid32, req_ready32}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        e;
    bit          ok_i, ok_r;
    int          lat, rsp_seen;
    exp_t        ex;
    mem32[32'h400] = 32'h00000005;
    mem32[32'h200] = 32'h000000F0;
    issue32(32'h400, 3'd0, ok_i);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    stray32 = 1'b1;
    rsp_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid32) rsp_seen++;
    end
    total++; if (rsp_seen !== 0) begin bad++; $display("FAIL rst_no_rsp: got %0d response cycles want 0", rsp_seen); end
    total++; if ({req_ready32, mem_req_valid32} !== 2'b10) begin
      bad++; $display("FAIL rst_idle: got ready/memvalid=%b want 10", {req_ready32, mem_req_valid32}); end
    exp_q.push_back('{data: 64'hFFFFFFF0, err: 1'b0});
    issue32(32'h200, 3'd3, ok_i);
    get_rsp32(d, e, ok_r, lat);
    ex = exp_q.pop_front();
    $display("load32 after reset addr=00000200 mode=3 data=%h err=%b lat=%0d", d, e, lat);
    total++; if (!(ok_i && ok_r)) begin bad++; $display("FAIL rst_handshake: got req=%b rsp=%b want 1 1", ok_i, ok_r); end
    total++; if ({e, d} !== {ex.err, ex.data[31:0]}) begin bad++; $display("FAIL rst_after_load: got err=%b data=%h want err=%b data=%h", e, d, ex.err, ex.data[31:0]); end
  endtask

  task automatic test_dw64();
    logic [63:0] d;
    logic [31:0] ga;
    logic        e;
    bit          gr, ok;
    int          lat;
    exp_t        ex;
    for (int i = 0; i < 4; i++) begin
      total++; if (req_ready64 !== 1'b1) begin bad++; $display("FAIL w64_ready[%0d]: got %b want 1", i, req_ready64); end
      exp_q.push_back('{data: W_EXP[i], err: W_ERR[i]});
      load64(W_ADDR[i], W_MODE[i], W_BEAT[i], gr, ga, d, e, ok, lat);
      ex = exp_q.pop_front();
      $display("load64 addr=%h mode=%0d data=%h err=%b lat=%0d", W_ADDR[i], W_MODE[i], d, e, lat);
      total++; if (!ok) begin bad++; $display("FAIL w64_rsp_timeout[%0d]: got 0 want 1", i); end
      total++; if ({e, d} !== {ex.err, ex.data}) begin bad++; $display("FAIL w64_result[%0d]: got err=%b data=%h want err=%b data=%h", i, e, d, ex.err, ex.data); end
      total++; if (gr !== !W_ERR[i]) begin bad++; $display("FAIL w64_bus_req[%0d]: got %b want %b", i, gr, !W_ERR[i]); end
      total++; if (lat !== (W_ERR[i] ? 1 : 3)) begin bad++; $display("FAIL w64_latency[%0d]: got %0d want %0d", i, lat, W_ERR[i] ? 1 : 3); end
      if (!W_ERR[i]) begin
        total++; if (ga !== W_MADR[i]) begin bad++; $display("FAIL w64_mem_addr[%0d]: got %h want %h", i, ga, W_MADR[i]); end
      end
    end
  endtask

  initial begin
    mem32[32'h100] = 32'h87654321;
    mem32[32'h104] = 32'hCCBBAA99;
    mem32[32'h500] = 32'h80FF7F01;
    mem32[32'h504] = 32'hDEADBEEF;
    test_reset();
    test_back_to_back();
    test_misaligned();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_dw64();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
